// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: drives an external full subtractor one bit
// per clock, LSB first, and collects the difference and final borrow.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one operand bit per cycle through the external full subtractor
// DONE  | one-cycle completion pulse, result already in diff/bout
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             fs_in0,
    output logic             fs_in1,
    output logic             fs_bin,
    input  logic             fs_sub,
    input  logic             fs_bout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        fs_in0    = 1'b0;
        fs_in1    = 1'b0;
        fs_bin    = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy   = 1'b1;
                fs_in0 = a_sh[0];
                fs_in1 = b_sh[0];
                fs_bin = borrow;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift right so bit [cnt] is always at position 0; the result
    // shifts in from the top so bit [cnt] lands in place after WIDTH steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        res    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= fs_bout;
                    res    <= {fs_sub, res[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        diff <= {fs_sub, res[WIDTH-1:1]};
                        bout <= fs_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: 8-bit instance checked every cycle against a
// timing/arithmetic model, plus an exhaustive 4-bit instance.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       bin = 1'b0;
    logic       fs_in0, fs_in1, fs_bin, fs_sub, fs_bout;
    logic       busy, done, bout;
    logic [7:0] diff;
    logic [1:0] fs_t;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       fs4_in0, fs4_in1, fs4_bin, fs4_sub, fs4_bout;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;
    logic [1:0] fs4_t;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Full subtractors as plain 2-bit arithmetic: {borrow, diff} = x - y - bi.
    assign fs_t    = {1'b0, fs_in0} - {1'b0, fs_in1} - {1'b0, fs_bin};
    assign fs_sub  = fs_t[0];
    assign fs_bout = fs_t[1];
    assign fs4_t   = {1'b0, fs4_in0} - {1'b0, fs4_in1} - {1'b0, fs4_bin};
    assign fs4_sub  = fs4_t[0];
    assign fs4_bout = fs4_t[1];

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .fs_in0(fs_in0), .fs_in1(fs_in1), .fs_bin(fs_bin),
        .fs_sub(fs_sub), .fs_bout(fs_bout),
        .busy(busy), .done(done), .diff(diff), .bout(bout));

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .fs_in0(fs4_in0), .fs_in1(fs4_in1), .fs_bin(fs4_bin),
        .fs_sub(fs4_sub), .fs_bout(fs4_bout),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an op accepted at edge acc is busy for cycles acc..acc+W-1,
    // done after edge acc+W, and the next start is taken from edge acc+W+2.
    int         e = 0;
    int         acc = 0;
    bit         valid = 0;
    logic [7:0] la, lb, m_diff = '0;
    logic       lbin, m_bout = 1'b0;
    logic [8:0] full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  = 0;
            e      = 0;
            m_diff = '0;
            m_bout = 1'b0;
        end else begin
            e++;
            if (valid && e == acc + W) begin
                m_diff = full[7:0];
                m_bout = full[8];
            end
            if (start && (!valid || e >= acc + W + 2)) begin
                valid = 1;
                acc   = e;
                la    = a;
                lb    = b;
                lbin  = bin;
                full  = {1'b0, a} - {1'b0, b} - {8'b0, bin};
            end
        end
    end

    int         k;
    logic       x_busy, x_done, x0, x1, xb;
    logic [7:0] mask;

    always @(negedge clk) begin
        if (rst_n) begin
            k      = e - acc;
            x_busy = valid && k >= 0 && k < W;
            x_done = valid && k == W;
            x0 = 1'b0; x1 = 1'b0; xb = 1'b0;
            if (x_busy) begin
                mask = 8'((1 << k) - 1);
                x0 = ((la >> k) & 8'd1) != 8'd0;
                x1 = ((lb >> k) & 8'd1) != 8'd0;
                xb = int'(la & mask) < int'(lb & mask) + int'(lbin);
            end
            chk("cyc busy", busy, x_busy);
            chk("cyc done", done, x_done);
            chk("cyc diff", diff, m_diff);
            chk("cyc bout", bout, m_bout);
            chk("cyc fs_in0", fs_in0, x0);
            chk("cyc fs_in1", fs_in1, x1);
            chk("cyc fs_bin", fs_bin, xb);
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                          input logic [7:0] xd, input logic xbo, input string nm, input bit rel);
        int  n;
        bit  seen;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1 if (done) seen = 1;
        end
        chk({nm, " latency"}, n, 8);
        chk({nm, " diff"}, diff, xd);
        chk({nm, " bout"}, bout, xbo);
        @(posedge clk);
    endtask

    initial begin
        int dc;
        int n;
        bit seen;
        logic [4:0] r4;

        #3;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst diff", diff, 0);
        chk("rst bout", bout, 0);
        chk("rst fs", {fs_in0, fs_in1, fs_bin}, 0);

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "5-3", 1'b1);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "3-5", 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "0-0-1", 1'b0);

        // Operand changes and start pulses while running are ignored.
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            a = ~a; b = b + 8'h11; bin = ~bin;
            start = (i == 2 || i == 5);
            @(posedge clk);
            #1 start = 1'b0;
            if (done) begin
                seen = 1;
                chk("ign done edge", i, 8);
                chk("ign diff", diff, 8'h1D);
                chk("ign bout", bout, 0);
            end
        end
        chk("ign done seen", seen, 1);
        repeat (3) @(posedge clk);

        // Start held high: back-to-back ops every W+2 edges.
        @(negedge clk);
        a = 8'hA0; b = 8'h0F; bin = 1'b0; start = 1'b1;
        dc = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                chk("hold done edge", i, 8 + 10 * dc);
                chk("hold diff", diff, 8'h91);
                chk("hold bout", bout, 0);
                dc++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("hold done count", dc, 3);
        repeat (12) @(posedge clk);

        // Reset asserted mid-clock in the 4th RUN cycle.
        @(negedge clk);
        a = 8'hC3; b = 8'h12; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort diff", diff, 0);
        chk("abort bout", bout, 0);
        chk("abort fs", {fs_in0, fs_in1, fs_bin}, 0);
        repeat (2) @(posedge clk);
        #1 chk("abort done held", done, 0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "post-rst", 1'b1);

        // Exhaustive 4-bit sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
                    @(posedge clk);
                    #1 start4 = 1'b0;
                    n = 0; seen = 0;
                    while (!seen && n < 10) begin
                        @(posedge clk);
                        n++;
                        #1 if (done4) seen = 1;
                    end
                    r4 = 5'(ia) - 5'(ib) - 5'(ic);
                    chk("w4 latency", n, 4);
                    chk("w4 result", {bout4, diff4}, r4);
                    @(posedge clk);
                end
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
